// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension unit: extension modes and
// the legality rule for the immediate/operand width pair.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'd0,
        MODE_ZEXT   = 2'd1,
        MODE_HIGH   = 2'd2,
        MODE_INSERT = 2'd3
    } imm_mode_e;

    // The operand must hold a whole number of immediate slots, and at least two.
    function automatic bit widths_ok(input int in_w, input int out_w);
        return (in_w >= 2) && (out_w >= 2 * in_w) && ((out_w % in_w) == 0);
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready buffer (main + skid). in_ready comes straight from a
// register, so there is no combinational path from out_ready back to in_ready.
module imm_skid_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         push, pop;

    assign push = in_valid && !skid_valid_q;
    assign pop  = main_valid_q && out_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (skid_valid_q) begin
            // Skid full means in_ready is low, so only a drain can happen here.
            if (pop) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || pop) begin
            main_valid_d = push;
            if (push) begin
                main_d = in_data;
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_d       = in_data;
        end
    end

    // NOTE: data registers are reset too, because the visible result must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/imm_ext_unit.sv
// Immediate-extension unit: sign/zero/upper extension or slot insertion into a
// held accumulator, with a registered result behind a two-entry skid buffer.
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter  int IN_W   = 16,
    parameter  int OUT_W  = 64,
    localparam int SLOTS  = OUT_W / IN_W,
    localparam int SLOT_W = (SLOTS > 2) ? $clog2(SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [1:0]        in_mode,
    input  logic [SLOT_W-1:0] in_slot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_imm,
    output logic [OUT_W-1:0]  acc
);

    if (!widths_ok(IN_W, OUT_W)) begin : g_bad_widths
        $error("imm_ext_unit: illegal widths IN_W=%0d OUT_W=%0d", IN_W, OUT_W);
    end

    imm_mode_e        mode;
    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] result;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             accept;

    assign mode   = imm_mode_e'(in_mode);
    assign accept = in_valid && in_ready;

    always_comb begin
        sext_val = {{(OUT_W - IN_W){in_imm[IN_W-1]}}, in_imm};
        result   = acc_q;
        case (mode)
            MODE_SEXT: result = sext_val;
            MODE_ZEXT: result = {{(OUT_W - IN_W){1'b0}}, in_imm};
            MODE_HIGH: result = sext_val << IN_W;
            MODE_INSERT: begin
                // An out-of-range slot matches nothing and leaves acc unchanged.
                for (int k = 0; k < SLOTS; k++) begin
                    if (in_slot == SLOT_W'(k)) begin
                        result[k*IN_W +: IN_W] = in_imm;
                    end
                end
            end
            default: result = acc_q;
        endcase
    end

    // acc moves on the same edge that captures the result, so a following
    // INSERT already sees it without a bubble.
    assign acc_d = accept ? result : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    imm_skid_buf #(
        .W(OUT_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_imm)
    );

    assign acc = acc_q;

endmodule

// File: tb/tb_imm_ext_unit.sv
// Bench for imm_ext_unit: directed spec vectors plus randomized traffic,
// scored against an arithmetic reference model and a result queue.
module tb_imm_ext_unit;
    import imm_ext_pkg::*;

    logic        clk;
    logic        rst_n;

    // 16/64 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode, in_slot;
    logic [63:0] out_imm, acc;

    // 12/48 instance
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [11:0] in_imm2;
    logic [1:0]  in_mode2, in_slot2;
    logic [47:0] out_imm2, acc2;

    int checks   = 0;
    int failures = 0;

    logic [63:0] q[$];
    logic [63:0] m_acc;
    logic [63:0] m_acc2;
    logic [63:0] pend2;
    bit          pend2_v;

    imm_ext_unit #(.IN_W(16), .OUT_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_slot(in_slot),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .acc(acc)
    );

    imm_ext_unit #(.IN_W(12), .OUT_W(48)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_imm(in_imm2),
        .in_mode(in_mode2), .in_slot(in_slot2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_imm(out_imm2),
        .acc(acc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference result computed with plain arithmetic on wide integers.
    function automatic logic [63:0] ref_ext(input int in_w, input int out_w,
                                            input logic [1:0] m, input logic [63:0] imm,
                                            input int sl, input logic [63:0] a);
        logic [127:0] omask = (128'd1 << out_w) - 128'd1;
        logic [127:0] imask = (128'd1 << in_w) - 128'd1;
        logic [127:0] v     = {64'd0, imm} & imask;
        logic [127:0] sx    = v[in_w-1] ? (v - (128'd1 << in_w)) : v;
        logic [127:0] r;
        case (m)
            2'd0:    r = sx;
            2'd1:    r = v;
            2'd2:    r = sx << in_w;
            default: begin
                if (sl * in_w < out_w)
                    r = ({64'd0, a} & ~(imask << (sl * in_w))) | (v << (sl * in_w));
                else
                    r = {64'd0, a};
            end
        endcase
        r = r & omask;
        return r[63:0];
    endfunction

    // One cycle on the 16/64 instance: check state, then drive and score.
    task automatic step(input logic v, input logic [1:0] m, input logic [15:0] imm,
                        input logic [1:0] sl, input logic ordy,
                        input bit use_exp, input logic [63:0] exp);
        bit          rdy;
        logic [63:0] r;
        @(negedge clk);
        rdy = (q.size() < 2);
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("acc", acc, m_acc);
        if (q.size() > 0) check("out_imm", out_imm, q[0]);
        in_valid  = v;
        in_mode   = m;
        in_imm    = imm;
        in_slot   = sl;
        out_ready = ordy;
        if (ordy && q.size() > 0) void'(q.pop_front());
        if (v && rdy) begin
            r = use_exp ? exp : ref_ext(16, 64, m, {48'd0, imm}, int'(sl), m_acc);
            m_acc = r;
            q.push_back(r);
        end
    endtask

    // One cycle on the 12/48 instance with the consumer always ready.
    task automatic step2(input logic v, input logic [1:0] m, input logic [11:0] imm,
                         input logic [1:0] sl, input bit use_exp, input logic [63:0] exp);
        @(negedge clk);
        check("in_ready2", 64'(in_ready2), 64'd1);
        check("out_valid2", 64'(out_valid2), 64'(pend2_v));
        if (pend2_v) begin
            check("out_imm2", {16'd0, out_imm2}, pend2);
            check("acc2", {16'd0, acc2}, pend2);
        end
        in_valid2 = v;
        in_mode2  = m;
        in_imm2   = imm;
        in_slot2  = sl;
        pend2_v   = v;
        if (v) begin
            pend2  = use_exp ? exp : ref_ext(12, 48, m, {52'd0, imm}, int'(sl), m_acc2);
            m_acc2 = pend2;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_mode = 0; in_imm = 0; in_slot = 0; out_ready = 1;
        in_valid2 = 0; in_mode2 = 0; in_imm2 = 0; in_slot2 = 0; out_ready2 = 1;
        m_acc = 0; m_acc2 = 0; pend2 = 0; pend2_v = 0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_imm", out_imm, 64'd0);
        check("rst_acc", acc, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Extension modes, one result per cycle.
        step(1, MODE_SEXT, 16'h0001, 0, 1, 1, 64'h0000_0000_0000_0001);
        step(1, MODE_SEXT, 16'h7FFF, 0, 1, 1, 64'h0000_0000_0000_7FFF);
        step(1, MODE_SEXT, 16'h8000, 0, 1, 1, 64'hFFFF_FFFF_FFFF_8000);
        step(1, MODE_SEXT, 16'hFFFF, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1, MODE_ZEXT, 16'h8000, 0, 1, 1, 64'h0000_0000_0000_8000);
        step(1, MODE_HIGH, 16'h8000, 0, 1, 1, 64'hFFFF_FFFF_8000_0000);
        step(1, MODE_HIGH, 16'h1234, 0, 1, 1, 64'h0000_0000_1234_0000);

        // Back-to-back constant build.
        step(1, MODE_ZEXT,   16'hDEF0, 0, 1, 1, 64'h0000_0000_0000_DEF0);
        step(1, MODE_INSERT, 16'h9ABC, 1, 1, 1, 64'h0000_0000_9ABC_DEF0);
        step(1, MODE_INSERT, 16'h5678, 2, 1, 1, 64'h0000_5678_9ABC_DEF0);
        step(1, MODE_INSERT, 16'h1234, 3, 1, 1, 64'h1234_5678_9ABC_DEF0);
        step(1, MODE_SEXT,   16'h8000, 0, 1, 1, 64'hFFFF_FFFF_FFFF_8000);
        step(1, MODE_INSERT, 16'h1234, 3, 1, 1, 64'h1234_FFFF_FFFF_8000);
        step(0, MODE_SEXT, 16'h0, 0, 1, 0, 64'd0);

        // Back-pressure: three offers, two accepted, then held, then drained.
        step(1, MODE_ZEXT, 16'h1111, 0, 0, 1, 64'h1111);
        step(1, MODE_ZEXT, 16'h2222, 0, 0, 1, 64'h2222);
        step(1, MODE_ZEXT, 16'h3333, 0, 0, 0, 64'd0);
        step(0, MODE_ZEXT, 16'h0, 0, 0, 0, 64'd0);
        step(0, MODE_ZEXT, 16'h0, 0, 1, 0, 64'd0);
        step(0, MODE_ZEXT, 16'h0, 0, 1, 0, 64'd0);
        step(0, MODE_ZEXT, 16'h0, 0, 1, 0, 64'd0);

        // Reset with both entries full, away from any clock edge.
        step(1, MODE_ZEXT, 16'hAAAA, 0, 0, 0, 64'd0);
        step(1, MODE_ZEXT, 16'hBBBB, 0, 0, 0, 64'd0);
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_acc", acc, 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        m_acc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, MODE_INSERT, 16'h00AA, 0, 1, 1, 64'h0000_0000_0000_00AA);
        step(0, MODE_SEXT, 16'h0, 0, 1, 0, 64'd0);

        // Randomized traffic with random back-pressure.
        repeat (400) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 0, 64'd0);
        end
        repeat (3) step(0, MODE_SEXT, 16'h0, 0, 1, 0, 64'd0);

        // 12/48 instance: acc is still zero here.
        step2(1, MODE_INSERT, 12'hABC, 3, 1, 64'hABC0_0000_0000);
        step2(1, MODE_SEXT,   12'h800, 0, 1, 64'hFFFF_FFFF_F800);
        repeat (60) begin
            step2(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 12'($urandom),
                  2'($urandom_range(0, 3)), 0, 64'd0);
        end
        step2(0, MODE_SEXT, 12'h0, 0, 0, 64'd0);
        step2(0, MODE_SEXT, 12'h0, 0, 0, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
